hdl_rr_arbiter_4req: RTL and testbench

//  - Round-robin arbiter sharing one resource between 4 requesters.
//  - Output is a one-hot grant plus a 2-bit encoded grant id, in the same encoding as the 4-to-2 encoder (req0->00 ... req3->11).
//  - Sits in front of shared datapath blocks.
//  - Sequences ownership: grant, hold, release, rotate priority.

---
 rtl/hdl_rr_arbiter_4req.sv | 109 ++++++++++
 tb/tb_hdl_rr_arbiter_4req.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdl_rr_arbiter_4req.sv
//------------------------------------------------------------------------------
// Module      : hdl_rr_arbiter_4req
// Description : Four-requester round-robin arbiter with a registered one-hot
//               grant and encoded grant id. Define ARB_TIMEOUT_EN to enable the
//               forced release after MAX_HOLD consecutive grant cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hdl_rr_arbiter_4req #(
    parameter int MAX_HOLD  = 8,
    parameter int PTR_RESET = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic [1:0] r_ptr;
    logic       w_pick_found;
    logic [1:0] w_pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
`else
    logic w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD != 0);
`endif

    // Scan downward so the closest requester at or after r_ptr wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = r_ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'b00;
            r_ptr    <= 2'(PTR_RESET);
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (r_state == c_st_idle) begin
                if (w_pick_found) begin
                    r_gnt    <= 4'b0001 << w_pick_idx;
                    r_gnt_id <= w_pick_idx;
                    r_state  <= c_st_grant;
`ifdef ARB_TIMEOUT_EN
                    r_hold_cnt <= 8'd0;
`endif
                end
            end else begin
                // Owner releasing (voluntarily or forced) drops to lowest priority.
                if (!req[r_gnt_id]) begin
                    r_gnt   <= 4'b0000;
                    r_ptr   <= r_gnt_id + 2'd1;
                    r_state <= c_st_idle;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_hold_cnt == c_hold_last) begin
                    r_gnt     <= 4'b0000;
                    r_ptr     <= r_gnt_id + 2'd1;
                    r_state   <= c_st_idle;
                    r_timeout <= 1'b1;
                end else if (r_hold_cnt != 8'hFF) begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                end
`endif
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = r_timeout;
`else
    assign timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdl_rr_arbiter_4req.sv
//------------------------------------------------------------------------------
// Module      : tb_hdl_rr_arbiter_4req
// Description : Self-checking bench for hdl_rr_arbiter_4req against a
//               cycle-level model of the arbitration rules.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hdl_rr_arbiter_4req;

    localparam int MAX_HOLD  = 4;
    localparam int PTR_RESET = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Model state: who owns the resource, who is first in line, how long held.
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_hold;
    bit m_to;

    hdl_rr_arbiter_4req #(
        .MAX_HOLD (MAX_HOLD),
        .PTR_RESET(PTR_RESET)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic [3:0] q);
        if (r) begin
            m_busy = 0; m_id = 0; m_ptr = PTR_RESET; m_hold = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_busy && q[(m_ptr + k) % 4]) begin
                        m_busy = 1; m_id = (m_ptr + k) % 4; m_hold = 0;
                    end
                end
            end else if (!q[m_id]) begin
                m_busy = 0; m_ptr = (m_id + 1) % 4;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_hold == MAX_HOLD - 1) begin
                    m_busy = 0; m_ptr = (m_id + 1) % 4; m_to = 1;
                end else if (m_hold < 255) begin
                    m_hold = m_hold + 1;
                end
`else
                m_hold = m_hold + 1;
`endif
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] g;
        g = m_busy ? 4'(1 << m_id) : 4'b0000;
        return {g, 2'(m_id), m_busy, m_to};
    endfunction

    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 4'b1111);
            checks++;
            if ({gnt, gnt_id, gnt_valid, timeout} !== 9'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got gnt=%b id=%b v=%b to=%b, required all zero", c, gnt, gnt_id, gnt_valid, timeout);
            end
        end
    endtask

    task automatic test_single();
        step(1'b0, 4'b0001);
        checks++;
        if ({gnt, gnt_id, gnt_valid} !== {4'b0001, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b id=%b v=%b, required 0001 00 1", gnt, gnt_id, gnt_valid);
        end
        step(1'b0, 4'b0000);
        checks++;
        if ({gnt, gnt_valid} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL single_release: got gnt=%b v=%b, required 0000 0", gnt, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        int seq [5] = '{0, 1, 2, 3, 0};
        step(1'b1, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 4'b1111);
            checks++;
            if ({gnt_id, gnt_valid} !== {2'(seq[g]), 1'b1} || exp_vec() !== {gnt, gnt_id, gnt_valid, timeout}) begin
                errors++;
                $display("FAIL rotation grant %0d: got id=%b v=%b gnt=%b, required id=%0d v=1", g, gnt_id, gnt_valid, gnt, seq[g]);
            end
            step(1'b0, 4'b1111);
            step(1'b0, 4'b1111 & ~4'(1 << seq[g]));
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rotation bubble %0d: got gnt=%b v=%b, required 0000 0", g, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b1001);
        checks++;
        if ({gnt, gnt_id} !== {4'b0001, 2'b00}) begin
            errors++;
            $display("FAIL wrap: got gnt=%b id=%b, required 0001 00", gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        checks++;
        if ({gnt, gnt_id} !== {4'b0010, 2'b01}) begin
            errors++;
            $display("FAIL reset_mid_pre: got gnt=%b id=%b, required 0010 01", gnt, gnt_id);
        end
        step(1'b1, 4'b0010);
        checks++;
        if ({gnt, gnt_valid, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_drop: got gnt=%b v=%b to=%b, required 0000 0 0", gnt, gnt_valid, timeout);
        end
        step(1'b0, 4'b0110);
        checks++;
        if ({gnt, gnt_id, gnt_valid} !== {4'b0010, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_ptr: got gnt=%b id=%b v=%b, required 0010 01 1", gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_hold();
        int on_cycles = 0;
        int pulses    = 0;
        step(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0100);
            if (gnt == 4'b0100 && pulses == 0) on_cycles++;
            if (timeout === 1'b1) pulses++;
            checks++;
            if ({gnt, gnt_id, gnt_valid, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL hold cycle %0d: got gnt=%b id=%b v=%b to=%b, required %b", c, gnt, gnt_id, gnt_valid, timeout, exp_vec());
            end
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (on_cycles != MAX_HOLD || pulses == 0) begin
            errors++;
            $display("FAIL hold_timeout: got %0d grant cycles %0d pulses, required %0d cycles and pulses", on_cycles, pulses, MAX_HOLD);
        end
`else
        checks++;
        if (on_cycles != 20 || pulses != 0) begin
            errors++;
            $display("FAIL hold_forever: got %0d grant cycles %0d pulses, required 20 cycles 0 pulses", on_cycles, pulses);
        end
`endif
        step(1'b1, 4'b0000);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, (c == 0) ? 4'b0100 : 4'b0101);
            checks++;
            if ({gnt, gnt_id, gnt_valid, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL hold_pair cycle %0d: got gnt=%b id=%b v=%b to=%b, required %b", c, gnt, gnt_id, gnt_valid, timeout, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] q;
        logic       r;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 49) == 0);
            q = 4'($urandom);
            if ($urandom_range(0, 3) == 0) q = 4'b0000;
            step(r, q);
            checks++;
            if ({gnt, gnt_id, gnt_valid, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d req=%b rst=%b: got gnt=%b id=%b v=%b to=%b, required %b", c, q, r, gnt, gnt_id, gnt_valid, timeout, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        m_busy = 0; m_id = 0; m_ptr = PTR_RESET; m_hold = 0; m_to = 0;
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_reset_mid();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
